// File: rtl/hubris_boot_pkg.sv
// Shared types and constants for the Hubris boot/run sequencer.
// Latency: n/a (package only).
// Backpressure: n/a. Optional checksum phase is enabled by HUBRIS_BOOT_CSUM_EN.
package hubris_boot_pkg;

  typedef enum logic [2:0] {
    LOAD_LEN  = 3'd0,
    LOAD_DATA = 3'd1,
    LOAD_CSUM = 3'd2,
    RUN       = 3'd3,
    HALTED    = 3'd4,
    ERROR     = 3'd5
  } state_t;

  localparam logic [3:0] WRITE_ALL  = 4'hF;
  localparam int         BYTE_CNT_W = 2;

  // The core owns memory port A and is out of reset only in these states.
  function automatic logic core_owns_port(input state_t s);
    return (s == RUN) || (s == HALTED);
  endfunction

  // States in which the byte stream is being consumed.
  function automatic logic is_load(input state_t s);
    return (s == LOAD_LEN) || (s == LOAD_DATA) || (s == LOAD_CSUM);
  endfunction

endpackage

// File: rtl/hubris_byte_word_assembler.sv
// Packs accepted bytes little-endian into 32-bit words (byte 0 -> [7:0]).
// Latency: word_vld/word_nx flag the 4th byte combinationally; word holds it from the next cycle.
// Backpressure: none; caller only strobes byte_vld on accepted bytes.
module hubris_byte_word_assembler
  import hubris_boot_pkg::*;
(
  input  logic        clk,
  input  logic        clear,
  input  logic        byte_vld,
  input  logic [7:0]  byte_dat,
  output logic [31:0] word,
  output logic [31:0] word_nx,
  output logic        word_vld
);

  logic [BYTE_CNT_W-1:0] cnt;
  logic [31:0]           word_q;

  // Newest byte enters at the top so that after four shifts byte 0 sits in [7:0].
  assign word_nx  = {byte_dat, word_q[31:8]};
  assign word_vld = byte_vld && (cnt == '1);
  assign word     = word_q;

  // Byte counter and shift register; clear discards any partial word.
  always_ff @(posedge clk) begin
    if (clear) begin
      cnt    <= '0;
      word_q <= '0;
    end else if (byte_vld) begin
      cnt    <= cnt + 1'b1;
      word_q <= word_nx;
    end
  end

endmodule

// File: rtl/hubris_boot_ctrl.sv
// Boot sequencer: loads a length-prefixed LE byte stream into memory port A, then releases the Hubris core.
// Latency: one memory write per word, issued the cycle after its 4th byte; core leaves reset the cycle after the last write.
// Backpressure: rx_ready registered, high only while loading. HUBRIS_BOOT_CSUM_EN adds a trailing checksum phase.
module hubris_boot_ctrl
  import hubris_boot_pkg::*;
#(
  parameter logic [31:0] LOAD_BASE = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 65536,
  parameter int          CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx_valid,
  input  logic [7:0]           rx_data,
  output logic                 rx_ready,
  input  logic                 restart,
  output logic                 core_reset,
  input  logic                 core_halt,
  input  logic                 core_en_a,
  input  logic [3:0]           core_we_a,
  input  logic [31:0]          core_addr_a,
  input  logic [31:0]          core_din_a,
  output logic                 mem_en_a,
  output logic [3:0]           mem_we_a,
  output logic [31:0]          mem_addr_a,
  output logic [31:0]          mem_din_a,
  output logic [2:0]           state,
  output logic                 error,
  output logic [31:0]          words_loaded,
  output logic [CNT_WIDTH-1:0] run_cycles
);

`ifdef HUBRIS_BOOT_CSUM_EN
  localparam state_t AFTER_DATA = LOAD_CSUM;
`else
  localparam state_t AFTER_DATA = RUN;
`endif

  state_t      state_q, state_nx;
  logic        wr_pending;
  logic [31:0] len;
  logic        accept;
  logic [31:0] asm_word, asm_word_nx;
  logic        asm_vld;
`ifdef HUBRIS_BOOT_CSUM_EN
  logic [31:0] sum;
`endif

  // restart wins over a byte offered in the same cycle.
  assign accept = rx_valid && rx_ready && !restart;
  assign state  = state_q;

  hubris_byte_word_assembler u_asm (
    .clk      (clk),
    .clear    (reset || restart),
    .byte_vld (accept),
    .byte_dat (rx_data),
    .word     (asm_word),
    .word_nx  (asm_word_nx),
    .word_vld (asm_vld)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= LOAD_LEN;
    else       state_q <= state_nx;
  end

  // Next-state decode; restart overrides everything including core_halt.
  always_comb begin
    state_nx = state_q;
    if (restart) begin
      state_nx = LOAD_LEN;
    end else begin
      case (state_q)
        LOAD_LEN: begin
          if (asm_vld) begin
            if (asm_word_nx == 32'd0)                 state_nx = AFTER_DATA;
            else if (asm_word_nx > 32'(MAX_WORDS))    state_nx = ERROR;
            else                                      state_nx = LOAD_DATA;
          end
        end
        LOAD_DATA: begin
          if (wr_pending && (words_loaded + 32'd1 == len)) state_nx = AFTER_DATA;
        end
`ifdef HUBRIS_BOOT_CSUM_EN
        LOAD_CSUM: begin
          if (asm_vld) state_nx = (asm_word_nx == sum) ? RUN : ERROR;
        end
`endif
        RUN: begin
          if (core_halt) state_nx = HALTED;
        end
        default: ;
      endcase
    end
  end

  // Load bookkeeping, handshake, core reset and run counter.
  always_ff @(posedge clk) begin
    if (reset || restart) begin
      wr_pending   <= 1'b0;
      words_loaded <= '0;
      len          <= '0;
      run_cycles   <= '0;
      error        <= 1'b0;
      rx_ready     <= 1'b0;
      core_reset   <= 1'b1;
`ifdef HUBRIS_BOOT_CSUM_EN
      sum          <= '0;
`endif
    end else begin
      wr_pending <= (state_q == LOAD_DATA) && asm_vld;
      if (wr_pending) words_loaded <= words_loaded + 32'd1;
      if ((state_q == LOAD_LEN) && asm_vld) len <= asm_word_nx;
      if (state_nx == ERROR) error <= 1'b1;
      // Low on the entry cycle after restart and never high outside loading.
      rx_ready   <= is_load(state_q) && is_load(state_nx);
      core_reset <= !core_owns_port(state_nx);
      if ((state_q == RUN) && !core_halt && (run_cycles != {CNT_WIDTH{1'b1}}))
        run_cycles <= run_cycles + 1'b1;
`ifdef HUBRIS_BOOT_CSUM_EN
      if (wr_pending) sum <= sum + asm_word;
`endif
    end
  end

  // Port A mux: core passthrough while running, otherwise the loader's write.
  always_comb begin
    mem_en_a   = wr_pending;
    mem_we_a   = wr_pending ? WRITE_ALL : 4'h0;
    mem_addr_a = LOAD_BASE + (words_loaded << 2);
    mem_din_a  = asm_word;
    if (core_owns_port(state_q)) begin
      mem_en_a   = core_en_a;
      mem_we_a   = core_we_a;
      mem_addr_a = core_addr_a;
      mem_din_a  = core_din_a;
    end
  end

endmodule

// File: tb/tb_hubris_boot_ctrl.sv
// Directed bench for hubris_boot_ctrl: load, run/halt, error, restart and optional checksum paths.
// Latency: n/a.
// Backpressure: byte driver waits on rx_ready with a bounded cycle budget.
module tb_hubris_boot_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_ready;
  logic        restart = 1'b0;
  logic        core_reset;
  logic        core_halt = 1'b0;
  logic        core_en_a = 1'b0;
  logic [3:0]  core_we_a = 4'h0;
  logic [31:0] core_addr_a = 32'h0;
  logic [31:0] core_din_a = 32'h0;
  logic        mem_en_a;
  logic [3:0]  mem_we_a;
  logic [31:0] mem_addr_a;
  logic [31:0] mem_din_a;
  logic [2:0]  state;
  logic        error;
  logic [31:0] words_loaded;
  logic [31:0] run_cycles;

  int checks = 0;
  int errors = 0;

  hubris_boot_ctrl dut (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .restart(restart), .core_reset(core_reset), .core_halt(core_halt),
    .core_en_a(core_en_a), .core_we_a(core_we_a), .core_addr_a(core_addr_a), .core_din_a(core_din_a),
    .mem_en_a(mem_en_a), .mem_we_a(mem_we_a), .mem_addr_a(mem_addr_a), .mem_din_a(mem_din_a),
    .state(state), .error(error), .words_loaded(words_loaded), .run_cycles(run_cycles)
  );

  always #5 clk = ~clk;

  // Write monitor: loader writes are those issued while the core is held in reset.
  logic [31:0] wq_addr[$];
  logic [31:0] wq_dat[$];
  logic [3:0]  wq_we[$];
  int cyc = 0;
  int wr_cyc_last = 0;
  int fall_cyc = -1;
  logic cr_prev = 1'b1;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (mem_en_a && core_reset) begin
      wq_addr.push_back(mem_addr_a);
      wq_dat.push_back(mem_din_a);
      wq_we.push_back(mem_we_a);
      wr_cyc_last = cyc;
    end
    if (cr_prev && !core_reset) fall_cyc = cyc;
    cr_prev = core_reset;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_writes();
    wq_addr.delete();
    wq_dat.delete();
    wq_we.delete();
  endtask

  task automatic send_byte(input logic [7:0] b, input int idle);
    int n;
    n = 0;
    repeat (idle) @(negedge clk);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    while (!rx_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) chk("rx_ready_timeout", {63'b0, rx_ready}, 64'd1);
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int idle);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], idle);
  endtask

  // Checksum trailer exists only when the feature is built in.
  task automatic send_csum(input logic [31:0] s, input int idle);
`ifdef HUBRIS_BOOT_CSUM_EN
    send_word(s, idle);
`else
    if (idle < 0) send_word(s, 0);
`endif
  endtask

  task automatic pulse_restart();
    @(negedge clk);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    #1;
  endtask

  task automatic wait_state(input logic [2:0] s, input int bound);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (state !== s && n < bound);
    chk("wait_state", {61'b0, state}, {61'b0, s});
  endtask

  logic [31:0] exp_w[3];

  initial begin
    exp_w[0] = 32'h0000_0013;
    exp_w[1] = 32'hDEAD_BEEF;
    exp_w[2] = 32'h1234_5678;

    // Reset values.
    repeat (3) @(negedge clk);
    chk("rst_state", {61'b0, state}, 64'd0);
    chk("rst_core_reset", {63'b0, core_reset}, 64'd1);
    chk("rst_rx_ready", {63'b0, rx_ready}, 64'd0);
    chk("rst_error", {63'b0, error}, 64'd0);
    chk("rst_words", {32'b0, words_loaded}, 64'd0);
    chk("rst_run_cycles", {32'b0, run_cycles}, 64'd0);
    chk("rst_mem_en", {63'b0, mem_en_a}, 64'd0);
    reset = 1'b0;

    // Back-to-back load of three words.
    clear_writes();
    send_word(32'd3, 0);
    for (int i = 0; i < 3; i++) send_word(exp_w[i], 0);
    send_csum(32'hF0E2_157A, 0);
    wait_state(3'd3, 30);
    #1;
    chk("l1_words", {32'b0, words_loaded}, 64'd3);
    chk("l1_core_reset", {63'b0, core_reset}, 64'd0);
    chk("l1_rx_ready", {63'b0, rx_ready}, 64'd0);
    chk("l1_nwr", 64'(wq_addr.size()), 64'd3);
    for (int i = 0; i < 3 && i < wq_addr.size(); i++) begin
      chk("l1_addr", {32'b0, wq_addr[i]}, 64'(4 * i));
      chk("l1_dat", {32'b0, wq_dat[i]}, {32'b0, exp_w[i]});
      chk("l1_we", {60'b0, wq_we[i]}, 64'hF);
    end
`ifndef HUBRIS_BOOT_CSUM_EN
    chk("l1_core_release", 64'(fall_cyc), 64'(wr_cyc_last + 1));
`endif

    // Run 100 cycles, then halt; port A passes through.
    chk("run_start", {32'b0, run_cycles}, 64'd0);
    core_en_a = 1'b1; core_we_a = 4'h3; core_addr_a = 32'h40; core_din_a = 32'h77;
    #1;
    chk("run_pass_we", {60'b0, mem_we_a}, 64'h3);
    chk("run_pass_addr", {32'b0, mem_addr_a}, 64'h40);
    repeat (100) @(negedge clk);
    core_halt = 1'b1;
    @(negedge clk);
    core_halt = 1'b0;
    #1;
    chk("halt_state", {61'b0, state}, 64'd4);
    chk("halt_cycles", {32'b0, run_cycles}, 64'd100);
    repeat (5) @(negedge clk);
    core_we_a = 4'hA; core_din_a = 32'h55AA;
    #1;
    chk("halt_frozen", {32'b0, run_cycles}, 64'd100);
    chk("halt_pass_we", {60'b0, mem_we_a}, 64'hA);
    chk("halt_pass_din", {32'b0, mem_din_a}, 64'h55AA);

    // Restart from HALTED with the core still requesting port A.
    pulse_restart();
    chk("rs_state", {61'b0, state}, 64'd0);
    chk("rs_core_reset", {63'b0, core_reset}, 64'd1);
    chk("rs_run_cycles", {32'b0, run_cycles}, 64'd0);
    chk("rs_words", {32'b0, words_loaded}, 64'd0);
    chk("rs_mem_en", {63'b0, mem_en_a}, 64'd0);
    chk("rs_mem_we", {60'b0, mem_we_a}, 64'd0);
    chk("rs_rx_ready", {63'b0, rx_ready}, 64'd0);
    @(negedge clk);
    #1;
    chk("rs_core_reset_2", {63'b0, core_reset}, 64'd1);
    core_en_a = 1'b0; core_we_a = 4'h0; core_addr_a = 32'h0; core_din_a = 32'h0;

    // Same load with 50% valid and a 10-cycle gap inside word 1.
    clear_writes();
    send_word(32'd3, 1);
    send_word(exp_w[0], 1);
    send_byte(exp_w[1][7:0], 1);
    send_byte(exp_w[1][15:8], 1);
    repeat (10) @(negedge clk);
    #1;
    chk("gap_words", {32'b0, words_loaded}, 64'd1);
    chk("gap_nwr", 64'(wq_addr.size()), 64'd1);
    send_byte(exp_w[1][23:16], 1);
    send_byte(exp_w[1][31:24], 1);
    send_word(exp_w[2], 1);
    send_csum(32'hF0E2_157A, 1);
    wait_state(3'd3, 30);
    #1;
    chk("l2_nwr", 64'(wq_addr.size()), 64'd3);
    for (int i = 0; i < 3 && i < wq_addr.size(); i++) begin
      chk("l2_addr", {32'b0, wq_addr[i]}, 64'(4 * i));
      chk("l2_dat", {32'b0, wq_dat[i]}, {32'b0, exp_w[i]});
    end
    chk("l2_words", {32'b0, words_loaded}, 64'd3);

    // Oversized length header.
    pulse_restart();
    clear_writes();
    send_word(32'd65537, 0);
    @(negedge clk);
    #1;
    chk("err_state", {61'b0, state}, 64'd5);
    chk("err_flag", {63'b0, error}, 64'd1);
    chk("err_core_reset", {63'b0, core_reset}, 64'd1);
    chk("err_rx_ready", {63'b0, rx_ready}, 64'd0);
    chk("err_nwr", 64'(wq_addr.size()), 64'd0);
    pulse_restart();
    chk("err_clr_flag", {63'b0, error}, 64'd0);
    chk("err_clr_state", {61'b0, state}, 64'd0);

    // Restart mid-word, then a clean single-word load.
    clear_writes();
    send_word(32'd2, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    pulse_restart();
    send_word(32'd1, 0);
    send_word(32'hCAFE_BABE, 0);
    send_csum(32'hCAFE_BABE, 0);
    wait_state(3'd3, 30);
    #1;
    chk("mid_nwr", 64'(wq_addr.size()), 64'd1);
    if (wq_addr.size() > 0) begin
      chk("mid_addr", {32'b0, wq_addr[0]}, 64'h0);
      chk("mid_dat", {32'b0, wq_dat[0]}, 64'hCAFE_BABE);
    end
    chk("mid_words", {32'b0, words_loaded}, 64'd1);

`ifdef HUBRIS_BOOT_CSUM_EN
    // Good checksum releases the core.
    pulse_restart();
    clear_writes();
    send_word(32'd2, 0);
    send_word(32'd1, 0);
    send_word(32'd2, 0);
    send_word(32'd3, 0);
    wait_state(3'd3, 30);
    #1;
    chk("csum_ok_core_reset", {63'b0, core_reset}, 64'd0);
    chk("csum_ok_nwr", 64'(wq_addr.size()), 64'd2);
    // Bad checksum latches the error and keeps the core in reset.
    pulse_restart();
    send_word(32'd2, 0);
    send_word(32'd1, 0);
    send_word(32'd2, 0);
    send_word(32'd4, 0);
    wait_state(3'd5, 30);
    #1;
    chk("csum_bad_error", {63'b0, error}, 64'd1);
    chk("csum_bad_core_reset", {63'b0, core_reset}, 64'd1);
`else
    // Zero-length program goes straight to RUN without writes.
    pulse_restart();
    clear_writes();
    send_word(32'd0, 0);
    wait_state(3'd3, 30);
    #1;
    chk("len0_nwr", 64'(wq_addr.size()), 64'd0);
    chk("len0_core_reset", {63'b0, core_reset}, 64'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
